// File: rtl/pipeline_controller.sv
// rtl/pipeline_controller.sv - pipelined main controller: decode, NZCV flags, condition squash
module pipeline_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] InstrD,
    input  logic [3:0]  ALUFlags,
    input  logic        FlushE,
    output logic [1:0]  RegSrcD,
    output logic [1:0]  ImmSrcD,
    output logic        ALUSrcE,
    output logic [3:0]  ALUControlE,
    output logic        MemtoRegE,
    output logic        BranchTakenE,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic        PCSrcW,
    output logic        BLW
);

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_ORR = 4'b0011;

    // InstrD carries Instr[31:12], so Instr[n] lives at InstrD[n-12]
    logic [3:0] cond_d;
    logic [1:0] op_d;
    logic       i_d;
    logic [3:0] cmd_d;
    logic       s_d;
    logic [3:0] rd_d;

    assign cond_d = InstrD[19:16];
    assign op_d   = InstrD[15:14];
    assign i_d    = InstrD[13];
    assign cmd_d  = InstrD[12:9];
    assign s_d    = InstrD[8];
    assign rd_d   = InstrD[3:0];

    logic unused_rn;
    assign unused_rn = &{1'b0, InstrD[7:4]};

    logic       regwrite_d, memtoreg_d, memwrite_d, alusrc_d, branch_d, bl_d, pcs_d;
    logic [3:0] alucontrol_d;
    logic [1:0] flagwrite_d;

    always_comb begin
        RegSrcD      = 2'b00;
        ImmSrcD      = 2'b00;
        alusrc_d     = 1'b0;
        alucontrol_d = ALU_ADD;
        regwrite_d   = 1'b0;
        memtoreg_d   = 1'b0;
        memwrite_d   = 1'b0;
        branch_d     = 1'b0;
        bl_d         = 1'b0;
        flagwrite_d  = 2'b00;
        case (op_d)
            2'b00: begin
                case (cmd_d)
                    4'b0100: begin
                        regwrite_d   = 1'b1;
                        alusrc_d     = i_d;
                        alucontrol_d = ALU_ADD;
                        flagwrite_d  = s_d ? 2'b11 : 2'b00;
                    end
                    4'b0010: begin
                        regwrite_d   = 1'b1;
                        alusrc_d     = i_d;
                        alucontrol_d = ALU_SUB;
                        flagwrite_d  = s_d ? 2'b11 : 2'b00;
                    end
                    4'b0000: begin
                        regwrite_d   = 1'b1;
                        alusrc_d     = i_d;
                        alucontrol_d = ALU_AND;
                        flagwrite_d  = s_d ? 2'b10 : 2'b00;
                    end
                    4'b1100: begin
                        regwrite_d   = 1'b1;
                        alusrc_d     = i_d;
                        alucontrol_d = ALU_ORR;
                        flagwrite_d  = s_d ? 2'b10 : 2'b00;
                    end
                    4'b1010: begin
                        alusrc_d     = i_d;
                        alucontrol_d = ALU_SUB;
                        flagwrite_d  = 2'b11;
                    end
                    default: ;
                endcase
            end
            2'b01: begin
                alusrc_d = 1'b1;
                ImmSrcD  = 2'b01;
                if (InstrD[8]) begin
                    regwrite_d = 1'b1;
                    memtoreg_d = 1'b1;
                end else begin
                    memwrite_d = 1'b1;
                    RegSrcD    = 2'b10;
                end
            end
            2'b10: begin
                branch_d = 1'b1;
                alusrc_d = 1'b1;
                ImmSrcD  = 2'b10;
                RegSrcD  = 2'b01;
                if (InstrD[12]) begin
                    bl_d       = 1'b1;
                    regwrite_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign pcs_d = (rd_d == 4'hF) && regwrite_d && !branch_d && !bl_d;

    logic       regwrite_e, memwrite_e, branch_e, bl_e, pcs_e;
    logic [1:0] flagwrite_e;
    logic [3:0] cond_e;

    // A flushed or reset E stage holds all-zero: cond EQ with no enables is inert
    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            regwrite_e  <= 1'b0;
            MemtoRegE   <= 1'b0;
            memwrite_e  <= 1'b0;
            ALUControlE <= 4'b0000;
            ALUSrcE     <= 1'b0;
            branch_e    <= 1'b0;
            bl_e        <= 1'b0;
            flagwrite_e <= 2'b00;
            pcs_e       <= 1'b0;
            cond_e      <= 4'b0000;
        end else begin
            regwrite_e  <= regwrite_d;
            MemtoRegE   <= memtoreg_d;
            memwrite_e  <= memwrite_d;
            ALUControlE <= alucontrol_d;
            ALUSrcE     <= alusrc_d;
            branch_e    <= branch_d;
            bl_e        <= bl_d;
            flagwrite_e <= flagwrite_d;
            pcs_e       <= pcs_d;
            cond_e      <= cond_d;
        end
    end

    logic [3:0] flags;
    logic       flag_n, flag_z, flag_c, flag_v, condex_e;

    assign {flag_n, flag_z, flag_c, flag_v} = flags;

    always_comb begin
        condex_e = 1'b0;
        case (cond_e)
            4'b0000: condex_e = flag_z;
            4'b0001: condex_e = !flag_z;
            4'b0010: condex_e = flag_c;
            4'b0011: condex_e = !flag_c;
            4'b0100: condex_e = flag_n;
            4'b0101: condex_e = !flag_n;
            4'b0110: condex_e = flag_v;
            4'b0111: condex_e = !flag_v;
            4'b1000: condex_e = flag_c && !flag_z;
            4'b1001: condex_e = !flag_c || flag_z;
            4'b1010: condex_e = (flag_n == flag_v);
            4'b1011: condex_e = (flag_n != flag_v);
            4'b1100: condex_e = !flag_z && (flag_n == flag_v);
            4'b1101: condex_e = flag_z || (flag_n != flag_v);
            4'b1110: condex_e = 1'b1;
            default: condex_e = 1'b0;
        endcase
    end

    // Flush does not gate this: the instruction already in E still retires its flags
    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= 4'b0000;
        end else begin
            if (flagwrite_e[1] && condex_e) flags[3:2] <= ALUFlags[3:2];
            if (flagwrite_e[0] && condex_e) flags[1:0] <= ALUFlags[1:0];
        end
    end

    assign BranchTakenE = branch_e && condex_e;

    logic memtoreg_m, pcsrc_m, bl_m;

    always_ff @(posedge clk) begin
        if (reset) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            memtoreg_m <= 1'b0;
            pcsrc_m    <= 1'b0;
            bl_m       <= 1'b0;
        end else begin
            RegWriteM  <= regwrite_e && condex_e;
            MemWriteM  <= memwrite_e && condex_e;
            memtoreg_m <= MemtoRegE;
            pcsrc_m    <= (pcs_e && condex_e) || BranchTakenE;
            bl_m       <= bl_e && condex_e;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            PCSrcW    <= 1'b0;
            BLW       <= 1'b0;
        end else begin
            RegWriteW <= RegWriteM;
            MemtoRegW <= memtoreg_m;
            PCSrcW    <= pcsrc_m;
            BLW       <= bl_m;
        end
    end

endmodule

// File: tb/tb_pipeline_controller.sv
// tb/tb_pipeline_controller.sv - scoreboard bench for pipeline_controller
module tb_pipeline_controller;

    logic        clk;
    logic        reset;
    logic [19:0] InstrD;
    logic [3:0]  ALUFlags;
    logic        FlushE;
    logic [1:0]  RegSrcD;
    logic [1:0]  ImmSrcD;
    logic        ALUSrcE;
    logic [3:0]  ALUControlE;
    logic        MemtoRegE;
    logic        BranchTakenE;
    logic        RegWriteM;
    logic        MemWriteM;
    logic        RegWriteW;
    logic        MemtoRegW;
    logic        PCSrcW;
    logic        BLW;

    pipeline_controller dut (
        .clk(clk), .reset(reset), .InstrD(InstrD), .ALUFlags(ALUFlags), .FlushE(FlushE),
        .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .MemtoRegE(MemtoRegE), .BranchTakenE(BranchTakenE), .RegWriteM(RegWriteM),
        .MemWriteM(MemWriteM), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .PCSrcW(PCSrcW), .BLW(BLW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [19:0] instr;
        logic        flush;
        logic [3:0]  af;
        logic [3:0]  d;
        logic [6:0]  e;
        logic [1:0]  m;
        logic [3:0]  w;
    } entry_t;

    entry_t     prog[$];
    logic [6:0] qe[$];
    logic [1:0] qm[$];
    logic [3:0] qw[$];
    int         ncyc;

    localparam logic [19:0] NOP = 20'hEC000;

    task automatic add(input logic [19:0] instr, input logic flush, input logic [3:0] af,
                       input logic [3:0] d, input logic [6:0] e, input logic [1:0] m,
                       input logic [3:0] w);
        entry_t x;
        x.instr = instr; x.flush = flush; x.af = af;
        x.d = d; x.e = e; x.m = m; x.w = w;
        prog.push_back(x);
    endtask

    task automatic run_cycle(input entry_t x, input int idx);
        logic [6:0] ee;
        logic [1:0] em;
        logic [3:0] ew;
        InstrD = x.instr;
        FlushE = x.flush;
        qe.push_back(x.e);
        qm.push_back(x.m);
        qw.push_back(x.w);
        #1;
        check($sformatf("dec[%0d]", idx), {28'd0, RegSrcD, ImmSrcD}, {28'd0, x.d});
        @(posedge clk);
        #1;
        ALUFlags = x.af;
        FlushE   = 1'b0;
        @(negedge clk);
        ncyc++;
        ee = qe.pop_front();
        check($sformatf("e[%0d]", idx),
              {25'd0, ALUControlE, ALUSrcE, MemtoRegE, BranchTakenE}, {25'd0, ee});
        if (ncyc >= 2) begin
            em = qm.pop_front();
            check($sformatf("m[%0d]", idx), {30'd0, RegWriteM, MemWriteM}, {30'd0, em});
        end
        if (ncyc >= 3) begin
            ew = qw.pop_front();
            check($sformatf("w[%0d]", idx),
                  {28'd0, RegWriteW, MemtoRegW, PCSrcW, BLW}, {28'd0, ew});
        end
    endtask

    initial begin
        reset    = 1'b1;
        InstrD   = NOP;
        ALUFlags = 4'h0;
        FlushE   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        FlushE = 1'b0;
        @(negedge clk);
        check("rst_e", {25'd0, ALUControlE, ALUSrcE, MemtoRegE, BranchTakenE}, 32'd0);
        check("rst_m", {30'd0, RegWriteM, MemWriteM}, 32'd0);
        check("rst_w", {28'd0, RegWriteW, MemtoRegW, PCSrcW, BLW}, 32'd0);
        reset = 1'b0;

        //  instr     fl  af    D        E             M      W
        add(20'hE0821, 0, 4'hF, 4'b0000, 7'b0000_000, 2'b10, 4'b1000); // ADD
        add(20'hE0421, 0, 4'hF, 4'b0000, 7'b0001_000, 2'b10, 4'b1000); // SUB
        add(20'hE0021, 0, 4'hF, 4'b0000, 7'b0010_000, 2'b10, 4'b1000); // AND
        add(20'hE1821, 0, 4'hF, 4'b0000, 7'b0011_000, 2'b10, 4'b1000); // ORR
        add(20'hE0221, 0, 4'hF, 4'b0000, 7'b0000_000, 2'b00, 4'b0000); // EOR -> NOP
        add(20'hE1510, 0, 4'h4, 4'b0000, 7'b0001_000, 2'b00, 4'b0000); // CMP, Z=1
        add(20'h0A000, 0, 4'hF, 4'b0110, 7'b0000_101, 2'b00, 4'b0010); // BEQ taken
        add(20'hE1510, 0, 4'h0, 4'b0000, 7'b0001_000, 2'b00, 4'b0000); // CMP, Z=0
        add(20'h0A000, 0, 4'hF, 4'b0110, 7'b0000_100, 2'b00, 4'b0000); // BEQ not taken
        add(20'hE1510, 0, 4'h4, 4'b0000, 7'b0001_000, 2'b00, 4'b0000); // CMP, Z=1
        add(20'h10821, 0, 4'hF, 4'b0000, 7'b0000_000, 2'b00, 4'b0000); // ADDNE squashed
        add(20'h15821, 0, 4'hF, 4'b1001, 7'b0000_100, 2'b00, 4'b0000); // STRNE squashed
        add(20'h00821, 0, 4'hF, 4'b0000, 7'b0000_000, 2'b10, 4'b1000); // ADDEQ
        add(20'hE5921, 1, 4'hF, 4'b0001, 7'b0000_000, 2'b00, 4'b0000); // LDR flushed
        add(20'hE5921, 0, 4'hF, 4'b0001, 7'b0000_110, 2'b10, 4'b1100); // LDR
        add(20'hEB000, 0, 4'hF, 4'b0110, 7'b0000_101, 2'b10, 4'b1011); // BL
        add(20'hE082F, 0, 4'hF, 4'b0000, 7'b0000_000, 2'b10, 4'b1010); // ADD R15
        add(20'hE2921, 0, 4'h9, 4'b0000, 7'b0000_100, 2'b10, 4'b1000); // ADDS imm, NZCV=1001
        add(20'hA0821, 0, 4'hF, 4'b0000, 7'b0000_000, 2'b10, 4'b1000); // ADDGE
        add(20'hB0821, 0, 4'hF, 4'b0000, 7'b0000_000, 2'b00, 4'b0000); // ADDLT
        add(20'hE0121, 0, 4'h6, 4'b0000, 7'b0010_000, 2'b10, 4'b1000); // ANDS: only N,Z
        add(20'h60821, 0, 4'hF, 4'b0000, 7'b0000_000, 2'b10, 4'b1000); // ADDVS
        add(20'h00821, 0, 4'hF, 4'b0000, 7'b0000_000, 2'b10, 4'b1000); // ADDEQ
        add(20'hF0821, 0, 4'hF, 4'b0000, 7'b0000_000, 2'b00, 4'b0000); // cond 1111
        add(20'h80821, 0, 4'hF, 4'b0000, 7'b0000_000, 2'b00, 4'b0000); // ADDHI
        add(20'h90821, 0, 4'hF, 4'b0000, 7'b0000_000, 2'b10, 4'b1000); // ADDLS
        for (int k = 0; k < 3; k++)
            add(NOP, 0, 4'hF, 4'b0000, 7'b0000_000, 2'b00, 4'b0000);

        ncyc = 0;
        for (int i = 0; i < prog.size(); i++)
            run_cycle(prog[i], i);

        // reset while STR sits in E, CMP in M, ADD R15 in W
        InstrD = 20'hE082F;
        @(posedge clk); #1;
        ALUFlags = 4'hF;
        InstrD   = 20'hE1510;
        @(posedge clk); #1;
        ALUFlags = 4'hF;
        InstrD   = 20'hE5821;
        @(posedge clk); #1;
        check("pre_rst_flags", {28'd0, dut.flags}, 32'hF);
        check("pre_rst_e", {25'd0, ALUControlE, ALUSrcE, MemtoRegE, BranchTakenE}, 32'b0000100);
        check("pre_rst_w", {28'd0, RegWriteW, MemtoRegW, PCSrcW, BLW}, 32'b1010);
        reset  = 1'b1;
        FlushE = 1'b0;
        InstrD = NOP;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst2_memwrite_m", {31'd0, MemWriteM}, 32'd0);
        check("rst2_flags", {28'd0, dut.flags}, 32'd0);
        check("rst2_w", {28'd0, RegWriteW, MemtoRegW, PCSrcW, BLW}, 32'd0);
        check("rst2_e", {25'd0, ALUControlE, ALUSrcE, MemtoRegE, BranchTakenE}, 32'd0);
        @(negedge clk);
        check("rst2_memwrite_m_next", {31'd0, MemWriteM}, 32'd0);
        check("rst2_w_next", {28'd0, RegWriteW, MemtoRegW, PCSrcW, BLW}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
